// File: rtl/instr_fetch_buffer.sv
// Instruction-fetch front end: PC register, ROM address drive and a
// small {pc, instr} FIFO feeding decode over a valid/ready handshake.
module instr_fetch_buffer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ROM_AW   = 6,
   parameter int          DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_dout,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_instr,
   output logic              misalign_err,
   output logic [15:0]       fetch_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   pc_q, pc_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [63:0]   mem_q [DEPTH];
   logic [63:0]   mem_d [DEPTH];
   logic [31:0]   head_pc_q, head_pc_d;
   logic [31:0]   head_instr_q, head_instr_d;
   logic [15:0]   fc_q, fc_d;
   logic          mis_q, mis_d;

   logic          pop;
   logic          push;
   logic [CW-1:0] remain;

   assign rom_addr     = pc_q[ROM_AW+1:2];
   assign out_valid    = (count_q != '0);
   assign out_pc       = head_pc_q;
   assign out_instr    = head_instr_q;
   assign misalign_err = mis_q;
   assign fetch_count  = fc_q;

   assign pop    = out_valid & out_ready;
   assign push   = !redirect & ((count_q < CW'(DEPTH)) | pop);
   // entries left after this cycle's pop, before the push lands
   assign remain = count_q - CW'(pop);

   // next-state: redirect wins; otherwise pop/push with head lookahead
   always_comb begin
      pc_d         = pc_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      head_pc_d    = head_pc_q;
      head_instr_d = head_instr_q;
      fc_d         = fc_q;
      mis_d        = redirect & (|redirect_pc[1:0]);
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end

      if (redirect) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         pc_d     = {redirect_pc[31:2], 2'b00};
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push) begin
            mem_d[wr_ptr_q] = {pc_q, rom_dout};
            wr_ptr_d        = wr_ptr_q + 1'b1;
            pc_d            = pc_q + 32'd4;
            fc_d            = fc_q + 16'd1;
         end
         count_d = count_q + CW'(push) - CW'(pop);
         // head shows the new entry directly when it lands in an empty slot
         if (count_d != '0) begin
            if (remain == '0) begin
               head_pc_d    = pc_q;
               head_instr_d = rom_dout;
            end else begin
               head_pc_d    = mem_q[rd_ptr_d][63:32];
               head_instr_d = mem_q[rd_ptr_d][31:0];
            end
         end
      end
   end

   // state registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         head_pc_q    <= '0;
         head_instr_q <= '0;
         fc_q         <= '0;
         mis_q        <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         pc_q         <= pc_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         head_pc_q    <= head_pc_d;
         head_instr_q <= head_instr_d;
         fc_q         <= fc_d;
         mis_q        <= mis_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule
